// File: rtl/input_port_buffer.sv
// Router input port: a DEPTH-entry flit FIFO plus a three-state control FSM
// that computes the XY route of the head flit and requests the switch arbiter.
module input_port_buffer #(
  parameter int              DATA_WIDTH = 8,
  parameter int              N_REGISTER = 3,
  parameter int              DEPTH      = 4,
  parameter logic [1:0]      X_ADDR     = 2'd1,
  parameter logic [1:0]      Y_ADDR     = 2'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [N_REGISTER-1:0] request,
  input  logic                  grant
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [N_REGISTER-1:0] CODE_L = N_REGISTER'(1);
  localparam logic [N_REGISTER-1:0] CODE_N = N_REGISTER'(2);
  localparam logic [N_REGISTER-1:0] CODE_E = N_REGISTER'(3);
  localparam logic [N_REGISTER-1:0] CODE_S = N_REGISTER'(4);
  localparam logic [N_REGISTER-1:0] CODE_W = N_REGISTER'(5);

  typedef enum logic [1:0] {
    EMPTY,
    ROUTE,
    REQ
  } state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count, count_next;
  logic [N_REGISTER-1:0]   route_q, route_next;
  logic [DATA_WIDTH-1:0]   head;
  logic [3:0]              head_dest;
  logic                    push, pop;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [N_REGISTER-1:0] xy_route(input logic [3:0] dest);
    logic [1:0] dx;
    logic [1:0] dy;
    dx = dest[3:2];
    dy = dest[1:0];
    if (dx > X_ADDR)      return CODE_E;
    else if (dx < X_ADDR) return CODE_W;
    else if (dy > Y_ADDR) return CODE_N;
    else if (dy < Y_ADDR) return CODE_S;
    else                  return CODE_L;
  endfunction

  assign head      = mem[rd_ptr];
  assign head_dest = head[7:4];

  // Reset forces the idle-looking outputs even before the reset edge lands.
  always_comb begin
    in_ready = (count < FULL_CNT) || !rst;
    push     = in_valid && (count < FULL_CNT) && rst;
    pop      = (state == REQ) && grant && rst;
    request  = '0;
    out_data = '0;
    if (state == REQ && rst) begin
      request  = route_q;
      out_data = head;
    end
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    route_next = route_q;
    unique case (state)
      EMPTY: begin
        if (count != '0) state_next = ROUTE;
      end
      ROUTE: begin
        route_next = xy_route(head_dest);
        state_next = REQ;
      end
      REQ: begin
        if (grant) state_next = (count_next != '0) ? ROUTE : EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= EMPTY;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      route_q <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      route_q <= route_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: a scoreboard queue of expected
// (flit, route) pairs is filled on accepted pushes and drained on grants.
module tb_input_port_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] request;
  logic       grant;

  typedef struct {
    logic [7:0] data;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];
  int   mcount  = 0;
  int   total   = 0;
  int   passed  = 0;

  input_port_buffer #(
    .DATA_WIDTH(8), .N_REGISTER(3), .DEPTH(4), .X_ADDR(2'd1), .Y_ADDR(2'd1)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .request(request), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference XY router for router (1,1).
  function automatic logic [2:0] route_model(input logic [7:0] f);
    if (f[7:6] > 2'd1)      return 3'd3;
    else if (f[7:6] < 2'd1) return 3'd5;
    else if (f[5:4] > 2'd1) return 3'd2;
    else if (f[5:4] < 2'd1) return 3'd4;
    else                    return 3'd1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one flit for one edge; the model decides acceptance from its count.
  task automatic applyStimulus(input logic [7:0] d);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    if (mcount < 4) begin
      e.data = d;
      e.code = route_model(d);
      sb.push_back(e);
      mcount++;
    end
    cycle();
    in_valid = 1'b0;
  endtask

  // Wait for the head request, compare against the scoreboard, hold, then grant.
  task automatic serve_one(input string tag, input int hold);
    int   waited;
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("[TB] FAIL %s_sb: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb[0];
    waited = 0;
    while (request === 3'd0 && waited < 20) begin
      cycle();
      waited++;
    end
    checkOutput({tag, "_req"}, 16'(request), 16'(e.code));
    checkOutput({tag, "_data"}, 16'(out_data), 16'(e.data));
    for (int h = 0; h < hold; h++) begin
      cycle();
      checkOutput({tag, "_hold"}, 16'(request), 16'(e.code));
    end
    grant = 1'b1;
    cycle();
    grant = 1'b0;
    void'(sb.pop_front());
    mcount--;
    checkOutput({tag, "_after"}, 16'(request), 16'd0);
  endtask

  initial begin
    exp_t e;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    grant    = 1'b0;
    cycle();
    cycle();
    checkOutput("rst_request", 16'(request), 16'd0);
    checkOutput("rst_out_data", 16'(out_data), 16'd0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
    rst = 1'b1;
    cycle();

    // Route and latency: request appears two edges after the accepting edge.
    applyStimulus(8'hA5);
    checkOutput("lat_t0_req", 16'(request), 16'd0);
    cycle();
    checkOutput("lat_route_req", 16'(request), 16'd0);
    checkOutput("lat_route_data", 16'(out_data), 16'd0);
    cycle();
    checkOutput("lat_req_east", 16'(request), 16'd3);
    checkOutput("lat_req_data", 16'(out_data), 16'hA5);
    serve_one("route_a5", 0);
    applyStimulus(8'h55);
    cycle();
    cycle();
    checkOutput("route_local", 16'(request), 16'd1);
    serve_one("route_55", 0);

    // Fill to capacity; the fifth flit must be dropped.
    applyStimulus(8'h0C);
    applyStimulus(8'hE3);
    applyStimulus(8'h67);
    applyStimulus(8'h49);
    checkOutput("full_ready", 16'(in_ready), 16'd0);
    applyStimulus(8'h00);
    checkOutput("full_ready_after_drop", 16'(in_ready), 16'd0);
    checkOutput("full_count", 16'(dut.count), 16'd4);
    serve_one("full0", 3);
    serve_one("full1", 1);
    serve_one("full2", 1);
    serve_one("full3", 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("full_no_extra", 16'(request), 16'd0);
    end

    // Simultaneous push and pop at count 2.
    applyStimulus(8'h91);
    applyStimulus(8'h15);
    for (int i = 0; i < 20 && request === 3'd0; i++) cycle();
    checkOutput("sim_head_req", 16'(request), 16'(route_model(8'h91)));
    checkOutput("sim_head_data", 16'(out_data), 16'h91);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    grant    = 1'b1;
    e.data = 8'h5A;
    e.code = route_model(8'h5A);
    sb.push_back(e);
    void'(sb.pop_front());
    cycle();
    in_valid = 1'b0;
    grant    = 1'b0;
    checkOutput("sim_count", 16'(dut.count), 16'd2);
    serve_one("sim_second", 0);
    serve_one("sim_third", 0);

    // Grants while EMPTY or ROUTE must be ignored.
    grant = 1'b1;
    cycle();
    cycle();
    checkOutput("spur_empty_req", 16'(request), 16'd0);
    checkOutput("spur_empty_count", 16'(dut.count), 16'd0);
    in_valid = 1'b1;
    in_data  = 8'hB0;
    cycle();
    in_valid = 1'b0;
    checkOutput("spur_t0_count", 16'(dut.count), 16'd1);
    checkOutput("spur_t0_req", 16'(request), 16'd0);
    cycle();
    checkOutput("spur_route_count", 16'(dut.count), 16'd1);
    checkOutput("spur_route_req", 16'(request), 16'd0);
    cycle();
    checkOutput("spur_req_code", 16'(request), 16'(route_model(8'hB0)));
    checkOutput("spur_req_data", 16'(out_data), 16'hB0);
    cycle();
    grant = 1'b0;
    checkOutput("spur_popped", 16'(dut.count), 16'd0);

    // Reset with three flits buffered discards them all.
    applyStimulus(8'h25);
    applyStimulus(8'h75);
    applyStimulus(8'hD5);
    for (int i = 0; i < 20 && request === 3'd0; i++) cycle();
    checkOutput("mid_req", 16'(request), 16'(route_model(8'h25)));
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1;
    checkOutput("mid_rst_ready_comb", 16'(in_ready), 16'd1);
    cycle();
    checkOutput("mid_rst_req", 16'(request), 16'd0);
    checkOutput("mid_rst_ready", 16'(in_ready), 16'd1);
    checkOutput("mid_rst_data", 16'(out_data), 16'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    mcount = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checkOutput("post_rst_idle", 16'(request), 16'd0);
    end

    // Twelve push/pop pairs wrap both pointers three times.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'(i * 37 + 11));
      serve_one("wrap", 0);
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
